// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed display bus: active-low anode enables plus active-low segment lines.
// The display driver is the master; the scan decoder only observes the bus.
interface seg7_scan_decoder_if #(
   parameter int NUM_DIGITS = 4
);
   logic [NUM_DIGITS-1:0] an;
   logic [6:0]            seg;

   modport master (output an, output seg);
   modport slave  (input an, input seg);
endinterface

// File: rtl/seg7_scan_decoder.sv
// Reads a multiplexed active-low 7-segment display bus and reconstructs the
// hex nibble shown on every digit, with per-digit status and capture/frame strobes.
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 16,
   localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   seg7_scan_decoder_if.slave      bus,
   output logic [4*NUM_DIGITS-1:0] hex_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   digit_blank,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    cap_strobe,
   output logic [IDX_W-1:0]        cap_idx,
   output logic                    frame_done
);

   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   logic [NUM_DIGITS-1:0] samp_an, prev_an;
   logic [6:0]            samp_seg, prev_seg;
   logic [7:0]            run_cnt, run_nxt;
   logic [NUM_DIGITS-1:0] seen, seen_upd;
   logic [7:0]            lows;
   logic                  samp_valid;
   logic [IDX_W-1:0]      samp_idx;
   logic                  capture;
   logic                  frame_complete;
   logic [6:0]            dec;

   // Result layout: {valid, blank, err, nibble}
   function automatic logic [6:0] decode(input logic [6:0] s);
      case (s)
         7'b1000000: decode = {3'b100, 4'h0};
         7'b1111001: decode = {3'b100, 4'h1};
         7'b0100100: decode = {3'b100, 4'h2};
         7'b0110000: decode = {3'b100, 4'h3};
         7'b0011001: decode = {3'b100, 4'h4};
         7'b0010010: decode = {3'b100, 4'h5};
         7'b0000010: decode = {3'b100, 4'h6};
         7'b1111000: decode = {3'b100, 4'h7};
         7'b0000000: decode = {3'b100, 4'h8};
         7'b0010000: decode = {3'b100, 4'h9};
         7'b0001000: decode = {3'b100, 4'hA};
         7'b0000011: decode = {3'b100, 4'hB};
         7'b1000110: decode = {3'b100, 4'hC};
         7'b0100001: decode = {3'b100, 4'hD};
         7'b0000110: decode = {3'b100, 4'hE};
         7'b0001110: decode = {3'b100, 4'hF};
         7'b1111111: decode = {3'b010, 4'h0};
         default:    decode = {3'b001, 4'h0};
      endcase
   endfunction

   always_comb begin
      lows     = '0;
      samp_idx = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (!samp_an[k]) begin
            lows     = lows + 8'd1;
            samp_idx = IDX_W'(k);
         end
      end
      samp_valid = (lows == 8'd1);
   end

   // The counter saturates at STABLE so a held value captures exactly once.
   always_comb begin
      run_nxt = '0;
      if (!samp_valid)
         run_nxt = '0;
      else if ({samp_an, samp_seg} != {prev_an, prev_seg})
         run_nxt = 8'd1;
      else if (run_cnt == STABLE)
         run_nxt = run_cnt;
      else
         run_nxt = run_cnt + 8'd1;
   end

   always_comb begin
      capture        = (run_nxt == STABLE) && (run_cnt != STABLE);
      seen_upd       = seen | (NUM_DIGITS'(1) << samp_idx);
      frame_complete = &seen_upd;
      dec            = decode(samp_seg);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         samp_an     <= '1;
         samp_seg    <= '1;
         prev_an     <= '1;
         prev_seg    <= '1;
         run_cnt     <= '0;
         seen        <= '0;
         hex_out     <= '0;
         digit_valid <= '0;
         digit_blank <= '0;
         digit_err   <= '0;
         cap_strobe  <= 1'b0;
         cap_idx     <= '0;
         frame_done  <= 1'b0;
      end else begin
         samp_an    <= bus.an;
         samp_seg   <= bus.seg;
         prev_an    <= samp_an;
         prev_seg   <= samp_seg;
         run_cnt    <= run_nxt;
         cap_strobe <= capture;
         frame_done <= capture && frame_complete;
         if (capture) begin
            cap_idx                           <= samp_idx;
            hex_out[4*int'(samp_idx) +: 4]    <= dec[3:0];
            digit_valid[samp_idx]             <= dec[6];
            digit_blank[samp_idx]             <= dec[5];
            digit_err[samp_idx]               <= dec[4];
            seen                              <= frame_complete ? '0 : seen_upd;
         end
      end
   end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reverse path of the hex-to-seven-segment encoder.
- Samples the multiplexed, active-low anode/segment bus that drives the 4-digit display and reconstructs the hex nibble shown on each digit.
- Provides per-digit valid/blank/error flags plus capture and frame strobes.
- Used on-chip as a display-path self-check and in benches to read back ALU results as shown to the user.

Parameters:
- NUM_DIGITS, 4, number of anodes/digits scanned.
- STABLE_CYCLES, 16, consecutive identical valid samples required before a capture; legal range 2..255.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- an  input  NUM_DIGITS  anode enables, active-low; an[k]=0 selects digit k.
- seg  input  7  segment bus, active-low, bit order {g,f,e,d,c,b,a}, same encoding as the display encoder.
- hex_out  output  4*NUM_DIGITS  decoded nibbles; digit k at [4k+3:4k].
- digit_valid  output  NUM_DIGITS  last capture of digit k decoded to a legal hex glyph.
- digit_blank  output  NUM_DIGITS  last capture of digit k was all-off (7'b1111111).
- digit_err  output  NUM_DIGITS  last capture of digit k was an unrecognised pattern.
- cap_strobe  output  1  one-cycle pulse on every capture.
- cap_idx  output  $clog2(NUM_DIGITS)  digit index of the current capture; valid with cap_strobe, holds otherwise.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - hex_out, digit_*, cap_strobe, cap_idx and frame_done go to 0.
  - Sample registers go to all-ones (idle bus); run counter and seen-mask go to 0.
  - Reset mid-run discards any partial stable run and partial frame.
- Input stage: {an,seg} is registered every edge into the sample register; the previous sample is also kept. No other synchronisation (same clock domain).
- Valid sample: exactly one bit of `an` is low. All-high or multiple-low samples are invalid and clear the run counter.
- Run counter:
  - Increments (saturating at STABLE_CYCLES) while the sample is valid and equal to the previous sample.
  - Loads 1 on a valid sample that differs from the previous one; clears on an invalid sample.
- Capture:
  - Occurs in the cycle the counter reaches exactly STABLE_CYCLES; outputs update at the following edge.
  - Only once per stable run; saturation prevents repeats.
  - Latency: if a new valid value is first sampled at edge e0 and held, cap_strobe and the updated digit fields are visible after edge e0+STABLE_CYCLES.
- Decode is the exact inverse of the encoder:
  - Glyph to nibble: 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 0001000→A, 0000011→B, 1000110→C, 0100001→D, 0000110→E, 0001110→F.
  - Legal glyph: nibble written; valid=1, blank=0, err=0.
  - 1111111: nibble 0; valid=0, blank=1, err=0.
  - Any other pattern: nibble 0; valid=0, blank=0, err=1.
  - Fields of non-captured digits hold.
- Frame tracking:
  - On each capture, seen[cap_idx] is set.
  - If the capture completes the mask (all ones including this capture), frame_done pulses together with cap_strobe and the mask clears to 0 at the same edge.
  - Repeat captures of one digit within a frame do not pulse frame_done.
- Simultaneous events: rst has priority over capture. A capture and a frame completion in the same cycle are both reported.

Test Plan:
- Reset: assert rst 2 cycles with arbitrary an/seg → all outputs 0; after release with an=4'b1111, no cap_strobe for 100 cycles.
- Single digit: an=4'b1110, seg=7'b0110000 held from edge e0 → cap_strobe and cap_idx=0 after edge e0+16; hex_out[3:0]=3, digit_valid=4'b0001; no second strobe while held 50 more cycles.
- Glitch reject: hold an=4'b1101, seg=7'b0001000 for 15 samples, then change seg → no capture; an=4'b1100 held 40 cycles → no capture.
- Full frame: scan digits 0..3 with glyphs A,B,C,D, 20 cycles each → hex_out=16'hDCBA, digit_valid=4'hF, exactly one frame_done, coincident with the digit-3 cap_strobe; rescanning digit 0 alone gives no frame_done.
- Blank/error: digit 2 seg=7'b1111111 → digit_blank[2]=1, hex_out[11:8]=0; digit 1 seg=7'b0111111 → digit_err[1]=1, digit_valid[1]=0.
- Reset mid-run: capture digits 0 and 1, assert rst during digit-2 run at count 10 → all cleared; a subsequent scan of digits 0..3 yields frame_done only after all four are captured.
